// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the multi-cycle data-memory responder.
// Holds the access-size codes, FSM state encoding and byte-lane mask helpers.
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Offset bits that must be zero for an access of this size to be aligned.
  function automatic logic [2:0] size_low_bits(input logic [1:0] size);
    logic [2:0] bits;
    case (size)
      SZ_B:    bits = 3'b000;
      SZ_H:    bits = 3'b001;
      SZ_W:    bits = 3'b011;
      default: bits = 3'b111;
    endcase
    return bits;
  endfunction

  // Byte lanes touched by an access of this size at an aligned offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational byte-lane steering for the data memory: extracts and
// sign/zero-extends load data, and merges store data into the old word.
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [2:0]  off,
  output logic [63:0] load_data,
  output logic [63:0] store_word
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  mask;

  // Right-align the addressed bytes, then extend to 64 bits.
  always_comb begin
    shifted = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_data = is_unsigned ? {56'd0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = is_unsigned ? {48'd0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data = is_unsigned ? {32'd0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Replace only the addressed lanes; all other bytes keep their old value.
  always_comb begin
    mask       = lane_mask(size, off);
    wshift     = wdata << {off, 3'b000};
    store_word = word;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) store_word[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle RV64 data memory answering MEM-stage load/store requests over
// separate request and response valid/ready handshakes.
// Optional macro DATA_MEM_MISALIGN_CHECK_EN: misaligned accesses return an
// error instead of being aligned down.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rdy_q;
  logic        accept, access;

  logic        wr_q, uns_q;
  logic [63:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic        cur_wr, cur_uns;
  logic [63:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;

  logic [AW-1:0] idx;
  logic [2:0]    off;
  logic          in_range, misalign, err;
  logic [63:0]   word, load_data, store_word;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic [63:0] mem [DEPTH_WORDS];

  // With a one-cycle latency the access happens on the accept edge, so the
  // live request is used in IDLE and the captured copy everywhere else.
  assign cur_wr    = (state_q == ST_IDLE) ? req_write    : wr_q;
  assign cur_uns   = (state_q == ST_IDLE) ? req_unsigned : uns_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr     : addr_q;
  assign cur_size  = (state_q == ST_IDLE) ? req_size     : size_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata    : wdata_q;

  assign idx      = cur_addr[AW+2:3];
  assign in_range = (cur_addr[63:AW+3] == '0);
  assign off      = cur_addr[2:0] & ~size_low_bits(cur_size);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign misalign = |(cur_addr[2:0] & size_low_bits(cur_size));
`else
  assign misalign = 1'b0;
`endif
  assign err  = !in_range || misalign;
  assign word = mem[idx];

  data_mem_lane_align u_align (
    .word        (word),
    .wdata       (cur_wdata),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .off         (off),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // FSM state, latency counter and post-reset ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  // Next-state, handshake and access-strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    access    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = rdy_q;
        if (req_valid && rdy_q) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Response registers, loaded once per access and held through back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q   <= err;
      rdata_q <= (err || cur_wr) ? 64'd0 : load_data;
    end
  end

  // Request capture on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  // Store commit; the array is deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (access && cur_wr && !err) mem[idx] <= store_word;
  end

endmodule
